// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer slice.
//   rob_entry_t : one ROB slot (valid, done, destination tag, arch reg,
//                 previous mapping, result data)
//   ARCH_REG_W  : architectural register index width
//   TAG_NONE    : physical tag meaning "no destination"
// Entry field widths are fixed here at the default tag/data widths.
package rob_pkg;

   localparam int unsigned ARCH_REG_W = 5;
   localparam int unsigned TAG_W      = 6;
   localparam int unsigned DATA_W     = 32;

   localparam logic [TAG_W-1:0] TAG_NONE = '0;

   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic [TAG_W-1:0]      tag_rd;
      logic [ARCH_REG_W-1:0] arch_rd;
      logic [TAG_W-1:0]      old_tag;
      logic [DATA_W-1:0]     data;
   } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bus bundle between the ROB and its neighbours (dispatch, issue queue
// lookups, CDB, retire/ARF/free list).
//   master : drives dispatch, lookup tags and CDB; observes ROB outputs
//   slave  : the reorder buffer itself
interface reorder_buffer_if
   import rob_pkg::*;
#(
   parameter int unsigned ROB_SIZE      = 64,
   parameter int unsigned ROB_SIZE_LOG2 = $clog2(ROB_SIZE),
   parameter int unsigned NUM_TAGS      = 64,
   parameter int unsigned NUM_TAGS_LOG2 = $clog2(NUM_TAGS),
   parameter int unsigned REG_SIZE      = 32,
   parameter int unsigned CDB_PORTS     = 3
);

   // dispatch
   logic                     disp_valid;
   logic [NUM_TAGS_LOG2-1:0] disp_tag_rd;
   logic [ARCH_REG_W-1:0]    disp_arch_rd;
   logic [NUM_TAGS_LOG2-1:0] disp_old_tag;
   logic [ROB_SIZE_LOG2-1:0] rob_tail;
   logic                     rob_full;

   // source lookups
   logic [NUM_TAGS_LOG2-1:0] lookup_tag_rs   [0:1];
   logic [REG_SIZE-1:0]      rob_data_rs     [0:1];
   logic                     rob_contains_rs [0:1];
   logic                     rob_ready_rs    [0:1];

   // common data bus
   logic                     cdb_valid     [0:CDB_PORTS-1];
   logic [ROB_SIZE_LOG2-1:0] cdb_rob_index [0:CDB_PORTS-1];
   logic [REG_SIZE-1:0]      cdb_data      [0:CDB_PORTS-1];

   // retire
   logic                     retire_valid;
   logic [ARCH_REG_W-1:0]    retire_arch_rd;
   logic [NUM_TAGS_LOG2-1:0] retire_tag;
   logic [NUM_TAGS_LOG2-1:0] retire_old_tag;
   logic [REG_SIZE-1:0]      retire_data;
   logic                     retire_wr_en;

   modport master (
      output disp_valid, disp_tag_rd, disp_arch_rd, disp_old_tag,
      output lookup_tag_rs,
      output cdb_valid, cdb_rob_index, cdb_data,
      input  rob_tail, rob_full,
      input  rob_data_rs, rob_contains_rs, rob_ready_rs,
      input  retire_valid, retire_arch_rd, retire_tag, retire_old_tag,
      input  retire_data, retire_wr_en
   );

   modport slave (
      input  disp_valid, disp_tag_rd, disp_arch_rd, disp_old_tag,
      input  lookup_tag_rs,
      input  cdb_valid, cdb_rob_index, cdb_data,
      output rob_tail, rob_full,
      output rob_data_rs, rob_contains_rs, rob_ready_rs,
      output retire_valid, retire_arch_rd, retire_tag, retire_old_tag,
      output retire_data, retire_wr_en
   );

endinterface

// File: rtl/reorder_buffer_lookup.sv
// rob_lookup: age-ordered tag CAM over the ROB entries.
//   entries_i  : current (registered) entry array
//   head_i     : oldest entry index; age is measured from here
//   tag_i      : physical tag to look up (0 never matches)
//   contains_o : a valid entry produces tag_i
//   ready_o    : value available (not contained, or contained and done)
//   data_o     : youngest matching entry's data, 0 when no match
module rob_lookup
   import rob_pkg::*;
#(
   parameter int unsigned ROB_SIZE      = 64,
   parameter int unsigned ROB_SIZE_LOG2 = $clog2(ROB_SIZE)
) (
   input  rob_entry_t               entries_i [ROB_SIZE],
   input  logic [ROB_SIZE_LOG2-1:0] head_i,
   input  logic [TAG_W-1:0]         tag_i,
   output logic                     contains_o,
   output logic                     ready_o,
   output logic [DATA_W-1:0]        data_o
);

   logic                     hit_done;
   logic [ROB_SIZE_LOG2-1:0] idx;

   // Walk oldest to youngest; a later hit overwrites, so the youngest wins.
   always_comb begin
      contains_o = 1'b0;
      hit_done   = 1'b0;
      data_o     = '0;
      idx        = '0;
      for (int unsigned i = 0; i < ROB_SIZE; i++) begin
         idx = head_i + ROB_SIZE_LOG2'(i);
         if (tag_i != TAG_NONE && entries_i[idx].valid &&
             entries_i[idx].tag_rd == tag_i) begin
            contains_o = 1'b1;
            hit_done   = entries_i[idx].done;
            data_o     = entries_i[idx].data;
         end
      end
      ready_o = !contains_o || hit_done;
   end

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order buffer between dispatch and commit.
//   clk, rst : clock, synchronous active-high reset
//   flush    : (only with ROB_FLUSH_EN defined) drop all in-flight entries
//   bus      : reorder_buffer_if.slave -- dispatch, two source lookups,
//              CDB capture, registered single-entry retire
// Optional feature macro: ROB_FLUSH_EN.
module reorder_buffer
   import rob_pkg::*;
#(
   parameter int unsigned ROB_SIZE      = 64,
   parameter int unsigned ROB_SIZE_LOG2 = $clog2(ROB_SIZE),
   parameter int unsigned NUM_TAGS      = 64,
   parameter int unsigned NUM_TAGS_LOG2 = $clog2(NUM_TAGS),
   parameter int unsigned REG_SIZE      = 32,
   parameter int unsigned CDB_PORTS     = 3
) (
   input logic clk,
   input logic rst,
`ifdef ROB_FLUSH_EN
   input logic flush,
`endif
   reorder_buffer_if.slave bus
);

   rob_entry_t               entries_q [ROB_SIZE];
   rob_entry_t               entries_d [ROB_SIZE];
   logic [ROB_SIZE_LOG2-1:0] head_q, head_d;
   logic [ROB_SIZE_LOG2-1:0] tail_q, tail_d;
   logic [ROB_SIZE_LOG2:0]   count_q, count_d;

   logic                     ret_valid_q, ret_valid_d;
   logic [ARCH_REG_W-1:0]    ret_arch_q, ret_arch_d;
   logic [NUM_TAGS_LOG2-1:0] ret_tag_q, ret_tag_d;
   logic [NUM_TAGS_LOG2-1:0] ret_old_q, ret_old_d;
   logic [REG_SIZE-1:0]      ret_data_q, ret_data_d;
   logic                     ret_wr_en_q, ret_wr_en_d;

   logic full;
   logic do_disp;
   logic do_ret;
   logic flush_w;

`ifdef ROB_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   assign full    = (count_q == (ROB_SIZE_LOG2+1)'(ROB_SIZE));
   assign do_disp = bus.disp_valid && !full && !flush_w;
   assign do_ret  = (count_q != '0) && entries_q[head_q].valid &&
                    entries_q[head_q].done && !flush_w;

   assign bus.rob_tail = tail_q;
   assign bus.rob_full = full;

   assign bus.retire_valid   = ret_valid_q;
   assign bus.retire_arch_rd = ret_arch_q;
   assign bus.retire_tag     = ret_tag_q;
   assign bus.retire_old_tag = ret_old_q;
   assign bus.retire_data    = ret_data_q;
   assign bus.retire_wr_en   = ret_wr_en_q;

   // Update order: CDB capture, then retire clear, then dispatch write.
   // CDB ports are applied highest to lowest so port 0 lands last and wins.
   always_comb begin
      int unsigned                p;
      logic [ROB_SIZE_LOG2-1:0]   idx;

      entries_d   = entries_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      ret_valid_d = 1'b0;
      ret_wr_en_d = 1'b0;
      ret_arch_d  = ret_arch_q;
      ret_tag_d   = ret_tag_q;
      ret_old_d   = ret_old_q;
      ret_data_d  = ret_data_q;
      p           = 0;
      idx         = '0;

      if (flush_w) begin
         for (int unsigned i = 0; i < ROB_SIZE; i++) begin
            entries_d[i].valid = 1'b0;
            entries_d[i].done  = 1'b0;
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         for (int unsigned k = 0; k < CDB_PORTS; k++) begin
            p   = CDB_PORTS - 1 - k;
            idx = bus.cdb_rob_index[p];
            if (bus.cdb_valid[p] && entries_q[idx].valid) begin
               entries_d[idx].done = 1'b1;
               entries_d[idx].data = bus.cdb_data[p];
            end
         end

         if (do_ret) begin
            ret_valid_d             = 1'b1;
            ret_arch_d              = entries_q[head_q].arch_rd;
            ret_tag_d               = entries_q[head_q].tag_rd;
            ret_old_d               = entries_q[head_q].old_tag;
            ret_data_d              = entries_q[head_q].data;
            ret_wr_en_d             = (entries_q[head_q].tag_rd != TAG_NONE);
            entries_d[head_q].valid = 1'b0;
            entries_d[head_q].done  = 1'b0;
            head_d                  = head_q + ROB_SIZE_LOG2'(1);
         end

         if (do_disp) begin
            entries_d[tail_q].valid   = 1'b1;
            entries_d[tail_q].done    = 1'b0;
            entries_d[tail_q].tag_rd  = bus.disp_tag_rd;
            entries_d[tail_q].arch_rd = bus.disp_arch_rd;
            entries_d[tail_q].old_tag = bus.disp_old_tag;
            entries_d[tail_q].data    = '0;
            tail_d                    = tail_q + ROB_SIZE_LOG2'(1);
         end

         if (do_disp && !do_ret) begin
            count_d = count_q + (ROB_SIZE_LOG2+1)'(1);
         end else if (do_ret && !do_disp) begin
            count_d = count_q - (ROB_SIZE_LOG2+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < ROB_SIZE; i++) begin
            entries_q[i] <= '0;
         end
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         ret_valid_q <= 1'b0;
         ret_arch_q  <= '0;
         ret_tag_q   <= '0;
         ret_old_q   <= '0;
         ret_data_q  <= '0;
         ret_wr_en_q <= 1'b0;
      end else begin
         entries_q   <= entries_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         ret_valid_q <= ret_valid_d;
         ret_arch_q  <= ret_arch_d;
         ret_tag_q   <= ret_tag_d;
         ret_old_q   <= ret_old_d;
         ret_data_q  <= ret_data_d;
         ret_wr_en_q <= ret_wr_en_d;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_lookup
      rob_lookup #(
         .ROB_SIZE      (ROB_SIZE),
         .ROB_SIZE_LOG2 (ROB_SIZE_LOG2)
      ) u_lookup (
         .entries_i  (entries_q),
         .head_i     (head_q),
         .tag_i      (bus.lookup_tag_rs[g]),
         .contains_o (bus.rob_contains_rs[g]),
         .ready_o    (bus.rob_ready_rs[g]),
         .data_o     (bus.rob_data_rs[g])
      );
   end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

   logic clk = 1'b0;
   logic rst = 1'b1;
`ifdef ROB_FLUSH_EN
   logic flush = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   reorder_buffer_if #(.ROB_SIZE(64), .NUM_TAGS(64), .REG_SIZE(32), .CDB_PORTS(3)) bus ();

   reorder_buffer #(.ROB_SIZE(64), .NUM_TAGS(64), .REG_SIZE(32), .CDB_PORTS(3)) dut (
      .clk   (clk),
      .rst   (rst),
`ifdef ROB_FLUSH_EN
      .flush (flush),
`endif
      .bus   (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.disp_valid   = 1'b0;
      bus.disp_tag_rd  = '0;
      bus.disp_arch_rd = '0;
      bus.disp_old_tag = '0;
      bus.lookup_tag_rs[0] = '0;
      bus.lookup_tag_rs[1] = '0;
      for (int p = 0; p < 3; p++) begin
         bus.cdb_valid[p]     = 1'b0;
         bus.cdb_rob_index[p] = '0;
         bus.cdb_data[p]      = '0;
      end
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic dispatch(input logic [5:0] tag, input logic [4:0] arch, input logic [5:0] old);
      bus.disp_valid   = 1'b1;
      bus.disp_tag_rd  = tag;
      bus.disp_arch_rd = arch;
      bus.disp_old_tag = old;
      step();
      bus.disp_valid = 1'b0;
   endtask

   task automatic cdb_write(input int port, input logic [5:0] idx, input logic [31:0] data);
      bus.cdb_valid[port]     = 1'b1;
      bus.cdb_rob_index[port] = idx;
      bus.cdb_data[port]      = data;
   endtask

   task automatic cdb_clear();
      for (int p = 0; p < 3; p++) bus.cdb_valid[p] = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      bus.lookup_tag_rs[0] = 6'd5;
      #1;
      checks++; if (bus.rob_tail !== 6'd0) begin errors++; $display("FAIL reset_tail got=%0d exp=0", bus.rob_tail); end
      checks++; if (bus.rob_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", bus.rob_full); end
      checks++; if (bus.retire_valid !== 1'b0) begin errors++; $display("FAIL reset_retire_valid got=%0b exp=0", bus.retire_valid); end
      checks++; if (bus.retire_wr_en !== 1'b0) begin errors++; $display("FAIL reset_retire_wr_en got=%0b exp=0", bus.retire_wr_en); end
      checks++; if (bus.retire_data !== 32'd0) begin errors++; $display("FAIL reset_retire_data got=%h exp=0", bus.retire_data); end
      checks++; if (bus.rob_contains_rs[0] !== 1'b0 || bus.rob_ready_rs[0] !== 1'b1)
         begin errors++; $display("FAIL reset_lookup got=c%0b r%0b exp=c0 r1", bus.rob_contains_rs[0], bus.rob_ready_rs[0]); end
   endtask

   task automatic test_retire_basic();
      do_reset();
      dispatch(6'd5, 5'd3, 6'd2);
      checks++; if (bus.rob_tail !== 6'd1) begin errors++; $display("FAIL basic_tail got=%0d exp=1", bus.rob_tail); end
      cdb_write(1, 6'd0, 32'hDEADBEEF);
      step();
      cdb_clear();
      checks++; if (bus.retire_valid !== 1'b0) begin errors++; $display("FAIL basic_retire_early got=%0b exp=0", bus.retire_valid); end
      step();
      checks++; if (bus.retire_valid !== 1'b1) begin errors++; $display("FAIL basic_retire_valid got=%0b exp=1", bus.retire_valid); end
      checks++; if (bus.retire_arch_rd !== 5'd3) begin errors++; $display("FAIL basic_arch got=%0d exp=3", bus.retire_arch_rd); end
      checks++; if (bus.retire_tag !== 6'd5) begin errors++; $display("FAIL basic_tag got=%0d exp=5", bus.retire_tag); end
      checks++; if (bus.retire_old_tag !== 6'd2) begin errors++; $display("FAIL basic_old_tag got=%0d exp=2", bus.retire_old_tag); end
      checks++; if (bus.retire_data !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_data got=%h exp=deadbeef", bus.retire_data); end
      checks++; if (bus.retire_wr_en !== 1'b1) begin errors++; $display("FAIL basic_wr_en got=%0b exp=1", bus.retire_wr_en); end
      step();
      bus.lookup_tag_rs[0] = 6'd5;
      #1;
      checks++; if (bus.retire_valid !== 1'b0) begin errors++; $display("FAIL basic_retire_once got=%0b exp=0", bus.retire_valid); end
      checks++; if (bus.rob_contains_rs[0] !== 1'b0) begin errors++; $display("FAIL basic_freed_lookup got=%0b exp=0", bus.rob_contains_rs[0]); end
   endtask

   task automatic test_lookup();
      do_reset();
      dispatch(6'd7, 5'd4, 6'd1);
      bus.lookup_tag_rs[0] = 6'd7;
      bus.lookup_tag_rs[1] = 6'd9;
      #1;
      checks++; if (bus.rob_contains_rs[0] !== 1'b1 || bus.rob_ready_rs[0] !== 1'b0)
         begin errors++; $display("FAIL lookup_pending got=c%0b r%0b exp=c1 r0", bus.rob_contains_rs[0], bus.rob_ready_rs[0]); end
      cdb_write(0, 6'd0, 32'h55);
      step();
      cdb_clear();
      checks++; if (bus.rob_contains_rs[0] !== 1'b1 || bus.rob_ready_rs[0] !== 1'b1 || bus.rob_data_rs[0] !== 32'h55)
         begin errors++; $display("FAIL lookup_done got=c%0b r%0b d%h exp=c1 r1 d55", bus.rob_contains_rs[0], bus.rob_ready_rs[0], bus.rob_data_rs[0]); end
      checks++; if (bus.rob_contains_rs[1] !== 1'b0 || bus.rob_ready_rs[1] !== 1'b1 || bus.rob_data_rs[1] !== 32'h0)
         begin errors++; $display("FAIL lookup_miss got=c%0b r%0b d%h exp=c0 r1 d0", bus.rob_contains_rs[1], bus.rob_ready_rs[1], bus.rob_data_rs[1]); end
      bus.lookup_tag_rs[1] = 6'd0;
      #1;
      checks++; if (bus.rob_contains_rs[1] !== 1'b0 || bus.rob_ready_rs[1] !== 1'b1)
         begin errors++; $display("FAIL lookup_tag0 got=c%0b r%0b exp=c0 r1", bus.rob_contains_rs[1], bus.rob_ready_rs[1]); end
   endtask

   task automatic test_youngest();
      do_reset();
      dispatch(6'd12, 5'd1, 6'd0);
      dispatch(6'd12, 5'd1, 6'd0);
      cdb_write(0, 6'd0, 32'hAA);
      step();
      cdb_clear();
      bus.lookup_tag_rs[0] = 6'd12;
      #1;
      checks++; if (bus.rob_contains_rs[0] !== 1'b1 || bus.rob_ready_rs[0] !== 1'b0 || bus.rob_data_rs[0] !== 32'h0)
         begin errors++; $display("FAIL youngest_pending got=c%0b r%0b d%h exp=c1 r0 d0", bus.rob_contains_rs[0], bus.rob_ready_rs[0], bus.rob_data_rs[0]); end
      cdb_write(2, 6'd1, 32'hBB);
      step();
      cdb_clear();
      checks++; if (bus.rob_ready_rs[0] !== 1'b1 || bus.rob_data_rs[0] !== 32'hBB)
         begin errors++; $display("FAIL youngest_done got=r%0b d%h exp=r1 dbb", bus.rob_ready_rs[0], bus.rob_data_rs[0]); end
   endtask

   task automatic test_full();
      do_reset();
      bus.disp_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         bus.disp_tag_rd  = 6'(i % 63 + 1);
         bus.disp_arch_rd = 5'(i % 32);
         bus.disp_old_tag = 6'd0;
         step();
      end
      checks++; if (bus.rob_full !== 1'b1 || bus.rob_tail !== 6'd0)
         begin errors++; $display("FAIL full_set got=f%0b t%0d exp=f1 t0", bus.rob_full, bus.rob_tail); end
      bus.disp_tag_rd = 6'd9;
      step();
      bus.disp_valid = 1'b0;
      checks++; if (bus.rob_full !== 1'b1 || bus.rob_tail !== 6'd0)
         begin errors++; $display("FAIL full_drop got=f%0b t%0d exp=f1 t0", bus.rob_full, bus.rob_tail); end
      cdb_write(0, 6'd0, 32'h100);
      step();
      cdb_clear();
      checks++; if (bus.rob_full !== 1'b1 || bus.retire_valid !== 1'b0)
         begin errors++; $display("FAIL full_pre_retire got=f%0b v%0b exp=f1 v0", bus.rob_full, bus.retire_valid); end
      // dispatch attempted on the retire edge must be refused
      bus.disp_valid  = 1'b1;
      bus.disp_tag_rd = 6'd9;
      step();
      bus.disp_valid = 1'b0;
      checks++; if (bus.retire_valid !== 1'b1 || bus.retire_tag !== 6'd1 || bus.retire_data !== 32'h100)
         begin errors++; $display("FAIL full_retire got=v%0b tag%0d d%h exp=v1 tag1 d100", bus.retire_valid, bus.retire_tag, bus.retire_data); end
      checks++; if (bus.rob_full !== 1'b0 || bus.rob_tail !== 6'd0)
         begin errors++; $display("FAIL full_after_retire got=f%0b t%0d exp=f0 t0", bus.rob_full, bus.rob_tail); end
      dispatch(6'd9, 5'd9, 6'd9);
      bus.lookup_tag_rs[0] = 6'd9;
      bus.lookup_tag_rs[1] = 6'd1;
      #1;
      checks++; if (bus.rob_full !== 1'b1 || bus.rob_tail !== 6'd1)
         begin errors++; $display("FAIL full_wrap got=f%0b t%0d exp=f1 t1", bus.rob_full, bus.rob_tail); end
      checks++; if (bus.rob_contains_rs[0] !== 1'b1 || bus.rob_contains_rs[1] !== 1'b1 || bus.rob_ready_rs[1] !== 1'b0)
         begin errors++; $display("FAIL full_wrap_lookup got=c%0b c%0b r%0b exp=c1 c1 r0", bus.rob_contains_rs[0], bus.rob_contains_rs[1], bus.rob_ready_rs[1]); end
   endtask

   task automatic test_out_of_order();
      do_reset();
      dispatch(6'd10, 5'd1, 6'd0);
      dispatch(6'd11, 5'd2, 6'd0);
      cdb_write(0, 6'd1, 32'hB1);
      step();
      cdb_clear();
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (bus.retire_valid !== 1'b0) begin errors++; $display("FAIL ooo_blocked got=%0b exp=0", bus.retire_valid); end
      end
      cdb_write(0, 6'd0, 32'hA0);
      step();
      cdb_clear();
      checks++; if (bus.retire_valid !== 1'b0) begin errors++; $display("FAIL ooo_latency got=%0b exp=0", bus.retire_valid); end
      step();
      checks++; if (bus.retire_valid !== 1'b1 || bus.retire_tag !== 6'd10 || bus.retire_data !== 32'hA0)
         begin errors++; $display("FAIL ooo_first got=v%0b tag%0d d%h exp=v1 tag10 da0", bus.retire_valid, bus.retire_tag, bus.retire_data); end
      step();
      checks++; if (bus.retire_valid !== 1'b1 || bus.retire_tag !== 6'd11 || bus.retire_data !== 32'hB1)
         begin errors++; $display("FAIL ooo_second got=v%0b tag%0d d%h exp=v1 tag11 db1", bus.retire_valid, bus.retire_tag, bus.retire_data); end
      step();
      checks++; if (bus.retire_valid !== 1'b0) begin errors++; $display("FAIL ooo_idle got=%0b exp=0", bus.retire_valid); end
   endtask

   task automatic test_cdb_priority();
      do_reset();
      for (int i = 0; i < 5; i++) dispatch(6'(20 + i), 5'(i), 6'd0);
      cdb_write(0, 6'd4, 32'h11);
      cdb_write(2, 6'd4, 32'h22);
      step();
      cdb_clear();
      bus.lookup_tag_rs[0] = 6'd24;
      #1;
      checks++; if (bus.rob_ready_rs[0] !== 1'b1 || bus.rob_data_rs[0] !== 32'h11)
         begin errors++; $display("FAIL cdb_priority got=r%0b d%h exp=r1 d11", bus.rob_ready_rs[0], bus.rob_data_rs[0]); end
      checks++; if (bus.retire_valid !== 1'b0) begin errors++; $display("FAIL cdb_no_retire got=%0b exp=0", bus.retire_valid); end
   endtask

   task automatic test_store();
      do_reset();
      dispatch(6'd0, 5'd0, 6'd0);
      cdb_write(2, 6'd0, 32'h99);
      step();
      cdb_clear();
      step();
      checks++; if (bus.retire_valid !== 1'b1 || bus.retire_wr_en !== 1'b0 || bus.retire_tag !== 6'd0)
         begin errors++; $display("FAIL store_retire got=v%0b w%0b tag%0d exp=v1 w0 tag0", bus.retire_valid, bus.retire_wr_en, bus.retire_tag); end
   endtask

`ifdef ROB_FLUSH_EN
   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 10; i++) dispatch(6'(30 + i), 5'(i), 6'd0);
      cdb_write(0, 6'd0, 32'h5);
      step();
      cdb_clear();
      flush = 1'b1;
      step();
      flush = 1'b0;
      bus.lookup_tag_rs[0] = 6'd30;
      #1;
      checks++; if (bus.retire_valid !== 1'b0) begin errors++; $display("FAIL flush_retire got=%0b exp=0", bus.retire_valid); end
      checks++; if (bus.rob_tail !== 6'd0 || bus.rob_full !== 1'b0)
         begin errors++; $display("FAIL flush_ptrs got=t%0d f%0b exp=t0 f0", bus.rob_tail, bus.rob_full); end
      checks++; if (bus.rob_contains_rs[0] !== 1'b0 || bus.rob_ready_rs[0] !== 1'b1)
         begin errors++; $display("FAIL flush_lookup got=c%0b r%0b exp=c0 r1", bus.rob_contains_rs[0], bus.rob_ready_rs[0]); end
      step();
      checks++; if (bus.retire_valid !== 1'b0) begin errors++; $display("FAIL flush_no_retire got=%0b exp=0", bus.retire_valid); end
   endtask
`endif

   initial begin
      clear_inputs();
      test_reset();
      test_retire_basic();
      test_lookup();
      test_youngest();
      test_full();
      test_out_of_order();
      test_cdb_priority();
      test_store();
`ifdef ROB_FLUSH_EN
      test_flush();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order buffer between rename/dispatch and architectural commit; consumer of the common data bus (CDB) alongside the issue queue.
- Allocates one entry per dispatched instruction and supplies `rob_tail` as that instruction's ROB index to the issue queue.
- Answers two source-tag lookups per cycle (`rob_data_rs` / `rob_contains_rs` / `rob_ready_rs`).
- Captures FU results from the CDB and retires at most one completed instruction per cycle, in program order, to the ARF and free list.

Parameters:
- ROB_SIZE, 64, number of entries (power of two).
- ROB_SIZE_LOG2, $clog2(ROB_SIZE), index width.
- NUM_TAGS, 64, physical tag count.
- NUM_TAGS_LOG2, $clog2(NUM_TAGS), tag width.
- REG_SIZE, 32, data width.
- CDB_PORTS, 3, CDB write ports (equals issue queue ISSUE_PORTS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- disp_valid  in  1  dispatch request.
- disp_tag_rd  in  NUM_TAGS_LOG2  destination physical tag; 0 means no destination (store, branch, x0).
- disp_arch_rd  in  5  destination architectural register.
- disp_old_tag  in  NUM_TAGS_LOG2  previous mapping of arch_rd, freed at retire.
- rob_tail  out  ROB_SIZE_LOG2  index the next dispatch will occupy.
- rob_full  out  1  no free entry.
- lookup_tag_rs  in  NUM_TAGS_LOG2 [0:1]  source tags to query.
- rob_data_rs  out  REG_SIZE [0:1]  matching entry's result.
- rob_contains_rs  out  1 [0:1]  an in-flight entry produces this tag.
- rob_ready_rs  out  1 [0:1]  value available: not contained, or contained and done.
- cdb_valid  in  1 [0:CDB_PORTS-1]  result valid.
- cdb_rob_index  in  ROB_SIZE_LOG2 [0:CDB_PORTS-1]  entry being completed.
- cdb_data  in  REG_SIZE [0:CDB_PORTS-1]  result value.
- retire_valid  out  1  registered; one retirement this cycle.
- retire_arch_rd  out  5  ARF write address.
- retire_tag  out  NUM_TAGS_LOG2  committed physical tag.
- retire_old_tag  out  NUM_TAGS_LOG2  tag returned to free list.
- retire_data  out  REG_SIZE  ARF write data.
- retire_wr_en  out  1  retire_valid and retire_tag != 0.

Behaviour:
- State:
  - head and tail pointers of ROB_SIZE_LOG2 bits, wrapping modulo ROB_SIZE.
  - count of ROB_SIZE_LOG2+1 bits.
  - Per entry: valid, done, tag_rd, arch_rd, old_tag, data.
- Reset: head=tail=count=0; all valid and done bits cleared; retire_valid=0; retire_wr_en=0; all other retire outputs 0.
- Combinational outputs:
  - rob_tail = tail.
  - rob_full = (count == ROB_SIZE).
- Dispatch: when disp_valid && !rob_full, at the edge:
  - write the entry at tail with valid=1, done=0, data=0;
  - tail increments.
  - disp_valid while full is dropped; upstream must stall on rob_full.
- CDB capture: for each port with cdb_valid, and the addressed entry valid, set done=1 and data=cdb_data.
  - Ports scanned 0..CDB_PORTS-1; the lowest-numbered port wins on a duplicate index.
  - A write to an invalid entry is ignored.
- Retire: evaluated on registered state.
  - If count != 0 and entry[head].valid && entry[head].done:
    - at the edge, register retire_* from entry[head];
    - clear entry[head].valid and done;
    - head increments.
  - Otherwise retire_valid=0 next cycle.
  - Latency: CDB write at edge k gives retire_valid high after edge k+1 at the earliest.
- count:
  - +1 on dispatch only, -1 on retire only, unchanged when both occur.
  - At full, a same-cycle retire does not admit a dispatch: rob_full is taken from the current count.
- Lookup: purely combinational over current entries.
  - Tag 0 never matches: contains=0, ready=1, data=0.
  - Tag matches more than one valid entry: the youngest (closest to tail) wins.
  - The same-cycle dispatch and same-cycle CDB writes are not visible; the issue queue forwards CDB itself.
  - No match: contains=0, ready=1, data=0 (the issue queue takes the ARF value).
- Wrap-around: indices ROB_SIZE-1 to 0 behave identically to any other increment; age order is computed relative to head.

Optional Feature:
- ROB_FLUSH_EN defined:
  - adds port flush (in, 1);
  - when high at an edge, invalidates all entries and sets head=tail=count=0;
  - suppresses that cycle's dispatch, CDB capture and retire; retire_valid=0 next cycle;
  - flush takes priority over rst-free activity but not over rst.
- ROB_FLUSH_EN undefined: port absent; entries leave only through retire.

Decomposition:
- Package rob_pkg:
  - typedef rob_entry_t struct (valid, done, tag_rd, arch_rd, old_tag, data);
  - localparam ARCH_REG_W=5;
  - localparam TAG_NONE=0.
- One sub-module, rob_lookup:
  - age-ordered tag CAM;
  - inputs: entry array, head, one tag;
  - outputs: contains/ready/data;
  - instantiated twice.

Test Plan:
- Reset, then dispatch tag 5 / arch 3 / old_tag 2, then CDB port 1 writes index 0 with 0xDEADBEEF -> two cycles later retire_valid=1, retire_arch_rd=3, retire_tag=5, retire_old_tag=2, retire_data=0xDEADBEEF, retire_wr_en=1.
- Dispatch tag 7 and query tag 7 before completion -> contains=1, ready=0; after CDB writes 0x55 -> contains=1, ready=1, data=0x55; query tag 9 -> contains=0, ready=1.
- Dispatch 64 instructions with no completion -> rob_full=1 and rob_tail=0; a 65th dispatch is dropped (count stays 64); retire one -> rob_full=0 the next cycle.
- Complete index 1 before index 0 -> no retire until index 0 completes, then index 0 and index 1 retire on consecutive cycles.
- Ports 0 and 2 both write index 4 with values 0x11 and 0x22 -> entry data=0x11; a store with tag 0 retires with retire_wr_en=0.
- With ROB_FLUSH_EN: 10 in-flight entries, assert flush -> count=0, rob_tail=0, retire_valid=0; a lookup of a previously in-flight tag returns contains=0.
